// File: rtl/serial_bus_transceiver.sv
// Half-duplex single-wire serial transceiver: start bit 0, DATA_W data bits LSB first,
// stop bit 1. The wire is released when not transmitting and idles high on the pull-up.
module serial_bus_transceiver #(
   parameter int DATA_W     = 8,
   parameter int BIT_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   inout  wire               RxTx,
   input  logic [DATA_W-1:0] tDP,
   input  logic              tEN,
   output logic              tDONE,
   output logic [DATA_W-1:0] rDP,
   input  logic              rEN,
   output logic              rDONE,
   output logic              rERR
);

   localparam int CW = $clog2(BIT_CYCLES);
   localparam int BW = $clog2(DATA_W);
   localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

   typedef enum logic [2:0] {T_IDLE, T_WAIT, T_START, T_DATA, T_STOP, T_DONE} txState_t;
   typedef enum logic [2:0] {R_OFF, R_HUNT, R_START, R_DATA, R_STOP} rxState_t;

   txState_t          txState;
   rxState_t          rxState;
   logic [CW-1:0]     txCnt, rxCnt;
   logic [BW-1:0]     txBit, rxBit;
   logic [DATA_W-1:0] txShift, rxShift;
   logic              driveEn, driveVal;
   logic              syncA, syncB, lineLast;

   assign RxTx = driveEn ? driveVal : 1'bz;

   // Synchronise the shared wire; lineLast keeps the previous synced value for edge detection.
   // Flops reset to the idle-high level so no false start edge follows reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syncA    <= 1'b1;
         syncB    <= 1'b1;
         lineLast <= 1'b1;
      end else begin
         syncA    <= RxTx;
         syncB    <= syncA;
         lineLast <= syncB;
      end
   end

   // Transmitter: carrier sense, then start/data/stop bits, then hold tDONE until tEN drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         txState  <= T_IDLE;
         txCnt    <= '0;
         txBit    <= '0;
         txShift  <= '0;
         driveEn  <= 1'b0;
         driveVal <= 1'b1;
         tDONE    <= 1'b0;
      end else begin
         case (txState)
            T_IDLE: begin
               if (tEN && !tDONE) begin
                  txState <= T_WAIT;
                  txCnt   <= '0;
               end
            end
            T_WAIT: begin
               if (!syncB) begin
                  txCnt <= '0;
               end else if (txCnt == CNT_LAST) begin
                  txCnt    <= '0;
                  txShift  <= tDP;
                  driveEn  <= 1'b1;
                  driveVal <= 1'b0;
                  txState  <= T_START;
               end else begin
                  txCnt <= txCnt + 1'b1;
               end
            end
            T_START: begin
               if (txCnt == CNT_LAST) begin
                  txCnt    <= '0;
                  txBit    <= '0;
                  driveVal <= txShift[0];
                  txState  <= T_DATA;
               end else begin
                  txCnt <= txCnt + 1'b1;
               end
            end
            T_DATA: begin
               if (txCnt == CNT_LAST) begin
                  txCnt <= '0;
                  if (txBit == BIT_LAST) begin
                     driveVal <= 1'b1;
                     txState  <= T_STOP;
                  end else begin
                     txBit    <= txBit + 1'b1;
                     txShift  <= txShift >> 1;
                     driveVal <= txShift[1];
                  end
               end else begin
                  txCnt <= txCnt + 1'b1;
               end
            end
            T_STOP: begin
               if (txCnt == CNT_LAST) begin
                  txCnt   <= '0;
                  driveEn <= 1'b0;
                  tDONE   <= 1'b1;
                  txState <= T_DONE;
               end else begin
                  txCnt <= txCnt + 1'b1;
               end
            end
            T_DONE: begin
               if (!tEN) begin
                  tDONE   <= 1'b0;
                  txState <= T_IDLE;
               end
            end
            default: txState <= T_IDLE;
         endcase
      end
   end

   // Receiver: armed by rEN, which takes priority over everything including a finishing stop bit.
   // Bits are sampled mid-bit on the synchronised line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxState <= R_OFF;
         rxCnt   <= '0;
         rxBit   <= '0;
         rxShift <= '0;
         rDP     <= '0;
         rDONE   <= 1'b0;
         rERR    <= 1'b0;
      end else begin
         rERR <= 1'b0;
         if (rEN) begin
            rDONE   <= 1'b0;
            rxCnt   <= '0;
            rxState <= R_HUNT;
         end else begin
            case (rxState)
               R_OFF: ;
               R_HUNT: begin
                  if (lineLast && !syncB) begin
                     rxCnt   <= '0;
                     rxState <= R_START;
                  end
               end
               R_START: begin
                  if (rxCnt == HALF_LAST) begin
                     rxCnt   <= '0;
                     rxBit   <= '0;
                     rxState <= syncB ? R_HUNT : R_DATA;
                  end else begin
                     rxCnt <= rxCnt + 1'b1;
                  end
               end
               R_DATA: begin
                  if (rxCnt == CNT_LAST) begin
                     rxCnt   <= '0;
                     rxShift <= {syncB, rxShift[DATA_W-1:1]};
                     if (rxBit == BIT_LAST) begin
                        rxState <= R_STOP;
                     end else begin
                        rxBit <= rxBit + 1'b1;
                     end
                  end else begin
                     rxCnt <= rxCnt + 1'b1;
                  end
               end
               R_STOP: begin
                  if (rxCnt == CNT_LAST) begin
                     rxCnt <= '0;
                     if (syncB) begin
                        rDP     <= rxShift;
                        rDONE   <= 1'b1;
                        rxState <= R_OFF;
                     end else begin
                        rERR    <= 1'b1;
                        rxState <= R_HUNT;
                     end
                  end else begin
                     rxCnt <= rxCnt + 1'b1;
                  end
               end
               default: rxState <= R_OFF;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_bus_transceiver.sv
// Directed bench for serial_bus_transceiver: reset, loopback, carrier sense,
// framing error, glitch rejection and receiver re-arm.
module tb_serial_bus_transceiver;

   logic       clk;
   logic       rst;
   logic [7:0] tDP;
   logic       tEN;
   logic       tDONE;
   logic [7:0] rDP;
   logic       rEN;
   logic       rDONE;
   logic       rERR;
   logic       busEn;
   logic       busVal;
   logic [9:0] frame;
   int         passCount;
   int         checkCount;
   wire        rxTx;

   assign rxTx = busEn ? busVal : 1'bz;
   pullup (rxTx);

   serial_bus_transceiver #(.DATA_W(8), .BIT_CYCLES(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .RxTx  (rxTx),
      .tDP   (tDP),
      .tEN   (tEN),
      .tDONE (tDONE),
      .rDP   (rDP),
      .rEN   (rEN),
      .rDONE (rDONE),
      .rERR  (rERR)
   );

   // Free-running bus clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   // Bench plays a remote node: one frame, 4 clocks per bit, then releases the wire.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
      logic [9:0] bits;
      bits = {stopBit, data, 1'b0};
      for (int b = 0; b < 10; b++) begin
         busEn  = 1'b1;
         busVal = bits[b];
         repeat (4) @(negedge clk);
      end
      busEn = 1'b0;
   endtask

   // Directed sequence; inputs change and outputs are sampled on falling edges.
   initial begin
      passCount  = 0;
      checkCount = 0;
      rst    = 1'b1;
      tDP    = 8'h00;
      tEN    = 1'b0;
      rEN    = 1'b0;
      busEn  = 1'b0;
      busVal = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_wire",  {7'b0, rxTx},  8'd1);
      checkOutput("rst_tdone", {7'b0, tDONE}, 8'd0);
      checkOutput("rst_rdp",   rDP,           8'h00);
      checkOutput("rst_rdone", {7'b0, rDONE}, 8'd0);
      checkOutput("rst_rerr",  {7'b0, rERR},  8'd0);
      rst = 1'b0;
      @(negedge clk);

      // Reset in the middle of a data bit releases the wire at once.
      tDP = 8'h00;
      tEN = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("t1_drive0", {7'b0, rxTx}, 8'd0);
      #1 rst = 1'b1;
      #1;
      checkOutput("t1_release", {7'b0, rxTx},  8'd1);
      checkOutput("t1_tdone",   {7'b0, tDONE}, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      tDP = 8'h96;
      frame = {1'b1, 8'h96, 1'b0};
      for (int k = 0; k <= 44; k++) begin
         @(negedge clk);
         if (k < 4) checkOutput("t1_sense", {7'b0, rxTx}, 8'd1);
         else if (k < 44) checkOutput("t1_bit", {7'b0, rxTx}, {7'b0, frame[(k-4)/4]});
         else checkOutput("t1_done", {7'b0, tDONE}, 8'd1);
         if (k == 43) checkOutput("t1_done_early", {7'b0, tDONE}, 8'd0);
      end
      tEN = 1'b0;
      @(negedge clk);
      checkOutput("t1_done_clr", {7'b0, tDONE}, 8'd0);
      checkOutput("t1_rdone",    {7'b0, rDONE}, 8'd0);

      // Loopback of 8'hA5 with the receiver armed.
      rEN = 1'b1;
      @(negedge clk);
      rEN = 1'b0;
      tDP = 8'hA5;
      tEN = 1'b1;
      frame = 10'b11_0100_1010;
      for (int k = 0; k <= 44; k++) begin
         @(negedge clk);
         if (k < 4) checkOutput("t2_sense", {7'b0, rxTx}, 8'd1);
         else if (k < 44) checkOutput("t2_bit", {7'b0, rxTx}, {7'b0, frame[(k-4)/4]});
         else begin
            checkOutput("t2_done",        {7'b0, tDONE}, 8'd1);
            checkOutput("t2_rdone_early", {7'b0, rDONE}, 8'd0);
         end
         if (k == 43) checkOutput("t2_done_early", {7'b0, tDONE}, 8'd0);
      end
      @(negedge clk);
      checkOutput("t2_rdone",     {7'b0, rDONE}, 8'd1);
      checkOutput("t2_rdp",       rDP,           8'hA5);
      checkOutput("t2_done_hold", {7'b0, tDONE}, 8'd1);
      tEN = 1'b0;
      @(negedge clk);
      checkOutput("t2_done_clr", {7'b0, tDONE}, 8'd0);

      // Carrier sense: wire held low 10 clocks, then 4 synced high clocks needed.
      tDP    = 8'hC3;
      tEN    = 1'b1;
      busEn  = 1'b1;
      busVal = 1'b0;
      repeat (10) @(negedge clk);
      busEn = 1'b0;
      for (int k = 10; k <= 15; k++) begin
         @(negedge clk);
         if (k < 15) checkOutput("t3_quiet", {7'b0, rxTx}, 8'd1);
         else checkOutput("t3_start", {7'b0, rxTx}, 8'd0);
      end
      repeat (39) @(negedge clk);
      checkOutput("t3_done_early", {7'b0, tDONE}, 8'd0);
      @(negedge clk);
      checkOutput("t3_done", {7'b0, tDONE}, 8'd1);
      tEN = 1'b0;
      @(negedge clk);
      checkOutput("t3_done_clr", {7'b0, tDONE}, 8'd0);

      // Framing error, then a good frame.
      rEN = 1'b1;
      @(negedge clk);
      rEN = 1'b0;
      checkOutput("t4_rearm", {7'b0, rDONE}, 8'd0);
      applyStimulus(8'h3C, 1'b0);
      @(negedge clk);
      checkOutput("t4_rerr",  {7'b0, rERR},  8'd1);
      checkOutput("t4_rdone", {7'b0, rDONE}, 8'd0);
      checkOutput("t4_rdp",   rDP,           8'hA5);
      @(negedge clk);
      checkOutput("t4_rerr_pulse", {7'b0, rERR}, 8'd0);
      repeat (3) @(negedge clk);
      applyStimulus(8'h81, 1'b1);
      @(negedge clk);
      checkOutput("t4_rdp_ok",   rDP,           8'h81);
      checkOutput("t4_rdone_ok", {7'b0, rDONE}, 8'd1);
      checkOutput("t4_rerr_ok",  {7'b0, rERR},  8'd0);

      // One-clock glitch while hunting must be ignored.
      rEN = 1'b1;
      @(negedge clk);
      rEN = 1'b0;
      busEn  = 1'b1;
      busVal = 1'b0;
      @(negedge clk);
      busEn = 1'b0;
      repeat (8) @(negedge clk);
      checkOutput("t5_no_rdone", {7'b0, rDONE}, 8'd0);
      applyStimulus(8'hFF, 1'b1);
      @(negedge clk);
      checkOutput("t5_rdp",   rDP,           8'hFF);
      checkOutput("t5_rdone", {7'b0, rDONE}, 8'd1);

      // Re-arm during the data bits of 8'h12 discards it.
      rEN = 1'b1;
      @(negedge clk);
      rEN = 1'b0;
      fork
         applyStimulus(8'h12, 1'b1);
         begin
            repeat (29) @(negedge clk);
            rEN = 1'b1;
            @(negedge clk);
            rEN = 1'b0;
         end
      join
      @(negedge clk);
      checkOutput("t6_discard_rdone", {7'b0, rDONE}, 8'd0);
      checkOutput("t6_discard_rdp",   rDP,           8'hFF);
      repeat (3) @(negedge clk);
      applyStimulus(8'h34, 1'b1);
      @(negedge clk);
      checkOutput("t6_rdp",   rDP,           8'h34);
      checkOutput("t6_rdone", {7'b0, rDONE}, 8'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
